// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo result-bus definitions: widths, the reserved idle tag,
// the buffered result record and the wrap-safe age comparison.
// The age comparison is only consumed when CDB_AGE_PRIO_EN is defined.
package cdb_arbiter_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int AGE_W  = 10;
  localparam int CDB_W  = TAG_W + DATA_W;

  // Tag 0 means "no producer": it never travels on the bus as a real result.
  localparam logic [TAG_W-1:0] TAG_NONE = 3'b000;

  // One buffered result as held in a source FIFO.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } result_t;

  // a is older than b when (a - b) mod 2^AGE_W has its MSB set. This stays
  // correct across counter wrap as long as live stamps span < 2^(AGE_W-1).
  function automatic logic age_older(input logic [AGE_W-1:0] a,
                                     input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result FIFO. Holds finished results until the CDB arbiter
// grants them. Full blocks pushes even when a pop happens the same cycle,
// so the ready seen by the source comes straight from registered state.
module cdb_arbiter_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    clr_ni,
  input  logic    push_i,
  input  logic    pop_i,
  input  result_t din_i,
  output result_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  result_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guard both operations here too so a misbehaving caller cannot corrupt
  // the pointers or the occupancy count.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; clearing the count is what discards buffered results on reset.
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: an entry is only read once the count says it is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus write-back arbiter. Each functional unit drops finished
// results into its own small FIFO; one result per cycle is granted and
// registered onto the CDB as {tag, data}, tag 0 meaning an idle bus.
// Default grant order is round-robin. Defining CDB_AGE_PRIO_EN switches
// to oldest-issue-stamp-first, with ties going to the lowest source index.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int  NSRC  = 3,
  parameter int  DEPTH = 2,
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [NSRC-1:0]        res_valid,
  input  logic [NSRC*TAG_W-1:0]  res_tag,
  input  logic [NSRC*DATA_W-1:0] res_data,
  input  logic [NSRC*AGE_W-1:0]  res_age,
  output logic [NSRC-1:0]        res_ready,
  output logic [CDB_W-1:0]       cdb,
  output logic                   cdb_valid,
  output logic [SRC_W-1:0]       cdb_src,
  output logic                   err_tag0
);

  logic [NSRC-1:0] fifo_full;
  logic [NSRC-1:0] fifo_empty;
  logic [NSRC-1:0] fifo_push;
  logic [NSRC-1:0] fifo_pop;
  logic [NSRC-1:0] tag0_try;
  result_t         fifo_head [NSRC];

  logic            grant_valid;
  logic [SRC_W-1:0] grant_idx;
  result_t         grant_entry;

  logic [CDB_W-1:0] cdb_q, cdb_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
  logic             err_q, err_d;
`ifndef CDB_AGE_PRIO_EN
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             unused_age;
`endif

  // One FIFO per source. A tag-0 result is never stored; it only raises
  // the sticky error, and only when the handshake would have accepted it.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [TAG_W-1:0] tag_in;
    result_t          entry_in;

    assign tag_in        = res_tag[gi*TAG_W +: TAG_W];
    assign entry_in      = {tag_in, res_data[gi*DATA_W +: DATA_W], res_age[gi*AGE_W +: AGE_W]};
    assign fifo_push[gi] = res_valid[gi] & ~fifo_full[gi] & (tag_in != TAG_NONE);
    assign tag0_try[gi]  = res_valid[gi] & ~fifo_full[gi] & (tag_in == TAG_NONE);
    assign fifo_pop[gi]  = grant_valid & (grant_idx == SRC_W'(gi));

    cdb_arbiter_result_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (CLK),
      .clr_ni  (CLR),
      .push_i  (fifo_push[gi]),
      .pop_i   (fifo_pop[gi]),
      .din_i   (entry_in),
      .head_o  (fifo_head[gi]),
      .full_o  (fifo_full[gi]),
      .empty_o (fifo_empty[gi])
    );
  end

  assign res_ready = ~fifo_full;

`ifdef CDB_AGE_PRIO_EN
  // Oldest head wins; a later source replaces the pick only if strictly older, so ties favour the lower index.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_entry = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!fifo_empty[i] && (!grant_valid || age_older(fifo_head[i].age, grant_entry.age))) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(i);
        grant_entry = fifo_head[i];
      end
    end
  end
`else
  // Round-robin search starting at rr_ptr; the first non-empty FIFO found is granted.
  always_comb begin
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_entry = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NSRC) begin
        cand = cand - NSRC;
      end
      cand_idx = SRC_W'(cand);
      if (!grant_valid && !fifo_empty[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
        grant_entry = fifo_head[cand_idx];
      end
    end
  end

  // Issue stamps travel through the FIFOs but do not steer round-robin grants.
  assign unused_age = ^grant_entry.age;
`endif

  // Bus next-state: an idle cycle drives tag 0 and keeps the last granted source index.
  always_comb begin
    cdb_d     = '0;
    cdb_src_d = cdb_src_q;
    err_d     = err_q | (|tag0_try);
`ifndef CDB_AGE_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    if (grant_valid) begin
      cdb_d     = {grant_entry.tag, grant_entry.data};
      cdb_src_d = grant_idx;
`ifndef CDB_AGE_PRIO_EN
      if (int'(grant_idx) == NSRC - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SRC_W'(1);
      end
`endif
    end
  end

  // Registered CDB, source index, sticky error and round-robin pointer.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cdb_q     <= '0;
      cdb_src_q <= '0;
      err_q     <= 1'b0;
`ifndef CDB_AGE_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      cdb_q     <= cdb_d;
      cdb_src_q <= cdb_src_d;
      err_q     <= err_d;
`ifndef CDB_AGE_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign cdb       = cdb_q;
  assign cdb_valid = |cdb_q[CDB_W-1:DATA_W];
  assign cdb_src   = cdb_src_q;
  assign err_tag0  = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-level model
// of the write-back stage. Honours CDB_AGE_PRIO_EN when it is defined.
module tb_cdb_arbiter;

  localparam int NSRC  = 3;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic [2:0]  res_valid;
  logic [8:0]  res_tag;
  logic [47:0] res_data;
  logic [29:0] res_age;
  logic [2:0]  res_ready;
  logic [18:0] cdb;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic        err_tag0;

  // Source side: one pending result per unit, held until accepted.
  logic        pv    [NSRC];
  logic [2:0]  ptag  [NSRC];
  logic [15:0] pdata [NSRC];
  logic [9:0]  page  [NSRC];

  // Model: plain per-source lists of buffered results plus bus expectations.
  int          cnt   [NSRC];
  logic [2:0]  etag  [NSRC][DEPTH];
  logic [15:0] edata [NSRC][DEPTH];
  logic [9:0]  eage  [NSRC][DEPTH];
  int          rr;
  logic [18:0] exp_cdb;
  logic [1:0]  exp_src;
  logic        exp_err;

  int   passed;
  int   total;
  bit   chk_en;

  logic [15:0] seen [3];
  int          nseen;

  cdb_arbiter #(
    .NSRC  (NSRC),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .res_age   (res_age),
    .res_ready (res_ready),
    .cdb       (cdb),
    .cdb_valid (cdb_valid),
    .cdb_src   (cdb_src),
    .err_tag0  (err_tag0)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    res_valid = {pv[2], pv[1], pv[0]};
    res_tag   = {ptag[2], ptag[1], ptag[0]};
    res_data  = {pdata[2], pdata[1], pdata[0]};
    res_age   = {page[2], page[1], page[0]};
  endtask

  task automatic newItem(input int s, input logic [2:0] t, input logic [15:0] d, input logic [9:0] a);
    pv[s]    = 1'b1;
    ptag[s]  = t;
    pdata[s] = d;
    page[s]  = a;
  endtask

  task automatic clearSources();
    for (int s = 0; s < NSRC; s++) begin
      pv[s]    = 1'b0;
      ptag[s]  = '0;
      pdata[s] = '0;
      page[s]  = '0;
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NSRC; s++) cnt[s] = 0;
    rr      = 0;
    exp_cdb = '0;
    exp_src = '0;
    exp_err = 1'b0;
  endtask

  function automatic logic [2:0] modelReady();
    logic [2:0] r;
    for (int s = 0; s < NSRC; s++) r[s] = (cnt[s] < DEPTH);
    return r;
  endfunction

  // One clock edge of the write-back stage, expressed on the model lists.
  task automatic modelEdge();
    logic [2:0] rdy;
    int         g;
    rdy = modelReady();
    g   = -1;
`ifdef CDB_AGE_PRIO_EN
    for (int s = 0; s < NSRC; s++) begin
      if (cnt[s] > 0) begin
        if (g < 0) g = s;
        else if (((int'(eage[s][0]) - int'(eage[g][0]) + 1024) % 1024) >= 512) g = s;
      end
    end
`else
    for (int k = 0; k < NSRC; k++) begin
      if (g < 0 && cnt[(rr + k) % NSRC] > 0) g = (rr + k) % NSRC;
    end
`endif
    if (g >= 0) begin
      exp_cdb = {etag[g][0], edata[g][0]};
      exp_src = 2'(g);
      for (int e = 0; e < DEPTH - 1; e++) begin
        etag[g][e]  = etag[g][e+1];
        edata[g][e] = edata[g][e+1];
        eage[g][e]  = eage[g][e+1];
      end
      cnt[g]--;
      rr = (g + 1) % NSRC;
    end else begin
      exp_cdb = '0;
    end
    for (int s = 0; s < NSRC; s++) begin
      if (pv[s] && rdy[s]) begin
        if (ptag[s] == 3'd0) begin
          exp_err = 1'b1;
        end else begin
          etag[s][cnt[s]]  = ptag[s];
          edata[s][cnt[s]] = pdata[s];
          eage[s][cnt[s]]  = page[s];
          cnt[s]++;
        end
        pv[s] = 1'b0;
      end
    end
  endtask

  task automatic tickClock();
    @(posedge CLK);
    modelEdge();
    #1;
    applyStimulus();
  endtask

  task automatic doReset();
    CLR = 1'b0;
    modelReset();
    clearSources();
    applyStimulus();
    @(negedge CLK);
    #2;
    CLR = 1'b1;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      checkOutput("cdb", 32'(cdb), 32'(exp_cdb));
      checkOutput("cdb_valid", 32'(cdb_valid), 32'(exp_cdb[18:16] != 3'd0));
      checkOutput("cdb_src", 32'(cdb_src), 32'(exp_src));
      checkOutput("res_ready", 32'(res_ready), 32'(modelReady()));
      checkOutput("err_tag0", 32'(err_tag0), 32'(exp_err));
    end
  end

  initial begin
    passed = 0;
    total  = 0;
    chk_en = 1'b0;
    clearSources();
    applyStimulus();
    modelReset();
    for (int s = 0; s < NSRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        etag[s][e]  = '0;
        edata[s][e] = '0;
        eage[s][e]  = '0;
      end
    end

    // Power-on reset.
    #12;
    checkOutput("reset_cdb", 32'(cdb), 32'd0);
    checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'd0);
    checkOutput("reset_cdb_src", 32'(cdb_src), 32'd0);
    checkOutput("reset_err", 32'(err_tag0), 32'd0);
    CLR = 1'b1;
    #1;
    checkOutput("reset_ready", 32'(res_ready), 32'h7);
    chk_en = 1'b1;

    // Single result from source 1.
    $display("[TB] single result");
    newItem(1, 3'b010, 16'h00A5, 10'd0);
    applyStimulus();
    tickClock();
    checkOutput("single_not_yet", 32'(cdb), 32'd0);
    tickClock();
    checkOutput("single_cdb", 32'(cdb), 32'(19'b010_0000000010100101));
    checkOutput("single_valid", 32'(cdb_valid), 32'd1);
    checkOutput("single_src", 32'(cdb_src), 32'd1);
    tickClock();
    checkOutput("single_idle", 32'(cdb), 32'd0);
    checkOutput("single_idle_valid", 32'(cdb_valid), 32'd0);

    // Contention: all three push together with equal ages.
    $display("[TB] contention");
    doReset();
    newItem(0, 3'd1, 16'h0101, 10'd5);
    newItem(1, 3'd2, 16'h0202, 10'd5);
    newItem(2, 3'd3, 16'h0303, 10'd5);
    applyStimulus();
    tickClock();
    for (int i = 0; i < 3; i++) begin
      tickClock();
      checkOutput("contend_src", 32'(cdb_src), 32'(i));
      checkOutput("contend_tag", 32'(cdb[18:16]), 32'(i + 1));
    end

    // Reset mid-burst with two results still queued.
    $display("[TB] reset mid-burst");
    doReset();
    newItem(0, 3'd1, 16'hA001, 10'd7);
    newItem(1, 3'd2, 16'hA002, 10'd7);
    newItem(2, 3'd3, 16'hA003, 10'd7);
    applyStimulus();
    tickClock();
    tickClock();
    checkOutput("burst_busy", 32'(cdb_valid), 32'd1);
    #2;
    CLR = 1'b0;
    modelReset();
    clearSources();
    applyStimulus();
    #1;
    checkOutput("burst_reset_cdb", 32'(cdb), 32'd0);
    checkOutput("burst_reset_valid", 32'(cdb_valid), 32'd0);
    @(negedge CLK);
    #2;
    CLR = 1'b1;
    #1;
    checkOutput("burst_ready", 32'(res_ready), 32'h7);
    for (int i = 0; i < 3; i++) begin
      tickClock();
      checkOutput("burst_no_stale", 32'(cdb), 32'd0);
    end

`ifndef CDB_AGE_PRIO_EN
    // Source 0 fills while sources 1 and 2 keep winning.
    $display("[TB] full fifo");
    doReset();
    nseen = 0;
    for (int i = 0; i < 3; i++) seen[i] = 16'hFFFF;
    for (int c = 0; c < 14; c++) begin
      if (c >= 1 && c <= 3 && !pv[0]) begin
        newItem(0, 3'd4, (c == 1) ? 16'h1111 : (c == 2) ? 16'h2222 : 16'h3333, 10'd0);
      end
      if (c < 4) begin
        if (!pv[1]) newItem(1, 3'd5, 16'($urandom), 10'd0);
        if (!pv[2]) newItem(2, 3'd6, 16'($urandom), 10'd0);
      end
      applyStimulus();
      tickClock();
      if (cdb_valid === 1'b1 && cdb_src === 2'd0 && nseen < 3) begin
        seen[nseen] = cdb[15:0];
        nseen++;
      end
      if (c == 2) checkOutput("full_ready0", 32'(res_ready[0]), 32'd0);
      if (c == 3) checkOutput("full_first_out", 32'(cdb), 32'({3'd4, 16'h1111}));
    end
    checkOutput("full_order0", 32'(seen[0]), 32'h1111);
    checkOutput("full_order1", 32'(seen[1]), 32'h2222);
    checkOutput("full_order2", 32'(seen[2]), 32'h3333);
`endif

    // Tag-0 push: dropped, sticky error until reset.
    $display("[TB] tag zero");
    doReset();
    newItem(2, 3'd0, 16'hBEEF, 10'd0);
    applyStimulus();
    tickClock();
    checkOutput("tag0_err", 32'(err_tag0), 32'd1);
    tickClock();
    checkOutput("tag0_no_bcast", 32'(cdb), 32'd0);
    tickClock();
    checkOutput("tag0_sticky", 32'(err_tag0), 32'd1);
    doReset();
    #1;
    checkOutput("tag0_cleared", 32'(err_tag0), 32'd0);

`ifdef CDB_AGE_PRIO_EN
    // Wrap-safe age priority.
    $display("[TB] age priority");
    doReset();
    newItem(2, 3'd5, 16'h2222, 10'h3FE);
    newItem(0, 3'd6, 16'h0000, 10'h001);
    applyStimulus();
    tickClock();
    tickClock();
    checkOutput("age_first", 32'(cdb), 32'({3'd5, 16'h2222}));
    checkOutput("age_first_src", 32'(cdb_src), 32'd2);
    tickClock();
    checkOutput("age_second_src", 32'(cdb_src), 32'd0);
`endif

    // Randomized traffic with one reset in the middle.
    $display("[TB] random traffic");
    doReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (!pv[s] && $urandom_range(0, 99) < 55) begin
          newItem(s, 3'($urandom_range(1, 7)), 16'($urandom), 10'($urandom));
        end
      end
      applyStimulus();
      tickClock();
      if (cyc == 300) doReset();
    end

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
